// File: rtl/snake_motion.sv
// Snake head/body motion engine: steps the snake once every STEP_DIV clocks,
// handles edge wrap, growth and self-collision, and serves a registered segment read port.
module snake_motion #(
    parameter int unsigned GRID_W   = 32,
    parameter int unsigned GRID_H   = 24,
    parameter int unsigned STEP_DIV = 6250000,
    parameter int unsigned MAX_LEN  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] direction,
    input  logic       dir_valid,
    input  logic       grow,
    input  logic [3:0] rd_idx,
    output logic [4:0] rd_x,
    output logic [4:0] rd_y,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [4:0] length,
    output logic       step,
    output logic       game_over
);

    localparam int unsigned CntW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

    localparam logic [4:0] DirUp    = 5'b00010;
    localparam logic [4:0] DirLeft  = 5'b00100;
    localparam logic [4:0] DirDown  = 5'b01000;
    localparam logic [4:0] DirRight = 5'b10000;

    typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [4:0]        cdir_q, cdir_d;
    logic [4:0]        pdir_q, pdir_d;
    logic              grow_pend_q, grow_pend_d;
    logic [4:0]        len_q, len_d;
    logic              step_q, step_d;
    logic [4:0]        seg_x_q [MAX_LEN];
    logic [4:0]        seg_y_q [MAX_LEN];

    logic              dir_ok, dir_opp, dir_acc;
    logic              move_now, grow_apply, hit, shift;
    logic [4:0]        nx, ny;

    always_comb begin
        dir_ok = dir_valid && (direction == DirUp || direction == DirLeft ||
                               direction == DirDown || direction == DirRight);
        dir_opp = (direction == DirUp    && cdir_q == DirDown)  ||
                  (direction == DirDown  && cdir_q == DirUp)    ||
                  (direction == DirLeft  && cdir_q == DirRight) ||
                  (direction == DirRight && cdir_q == DirLeft);
        dir_acc = dir_ok && !dir_opp;
    end

    // Next head position with toroidal wrap; up decrements y.
    always_comb begin
        nx = seg_x_q[0];
        ny = seg_y_q[0];
        case (pdir_q)
            DirUp:    ny = (seg_y_q[0] == 5'd0) ? 5'(GRID_H - 1) : seg_y_q[0] - 5'd1;
            DirDown:  ny = (seg_y_q[0] == 5'(GRID_H - 1)) ? 5'd0 : seg_y_q[0] + 5'd1;
            DirLeft:  nx = (seg_x_q[0] == 5'd0) ? 5'(GRID_W - 1) : seg_x_q[0] - 5'd1;
            DirRight: nx = (seg_x_q[0] == 5'(GRID_W - 1)) ? 5'd0 : seg_x_q[0] + 5'd1;
            default:  ;
        endcase
    end

    // The tail vacates its cell on a non-growing move, so it cannot be hit.
    always_comb begin
        move_now   = (state_q == StRun) && (cnt_q == CntW'(STEP_DIV - 1));
        grow_apply = grow_pend_q && (len_q < 5'(MAX_LEN));
        hit        = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((5'(i) < len_q) && !((5'(i) == len_q - 5'd1) && !grow_apply) &&
                (seg_x_q[i] == nx) && (seg_y_q[i] == ny)) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cdir_d      = cdir_q;
        pdir_d      = pdir_q;
        grow_pend_d = grow_pend_q;
        len_d       = len_q;
        step_d      = 1'b0;
        shift       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dir_acc) begin
                    pdir_d  = direction;
                    state_d = StRun;
                    cnt_d   = '0;
                end
                if (grow) grow_pend_d = 1'b1;
            end
            StRun: begin
                if (dir_acc) pdir_d = direction;
                cnt_d = move_now ? '0 : cnt_q + CntW'(1);
                if (move_now) begin
                    cdir_d = pdir_q;
                    if (hit) begin
                        state_d = StOver;
                    end else begin
                        shift       = 1'b1;
                        step_d      = 1'b1;
                        grow_pend_d = 1'b0;
                        if (grow_apply) len_d = len_q + 5'd1;
                    end
                end
                if (grow) grow_pend_d = 1'b1;
            end
            StOver: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cdir_q      <= DirRight;
            pdir_q      <= DirRight;
            grow_pend_q <= 1'b0;
            len_q       <= 5'd3;
            step_q      <= 1'b0;
            rd_x        <= 5'd31;
            rd_y        <= 5'd31;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < 3) ? 5'(16 - i) : 5'd0;
                seg_y_q[i] <= (i < 3) ? 5'd12 : 5'd0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cdir_q      <= cdir_d;
            pdir_q      <= pdir_d;
            grow_pend_q <= grow_pend_d;
            len_q       <= len_d;
            step_q      <= step_d;
            if ({1'b0, rd_idx} < len_q) begin
                rd_x <= seg_x_q[rd_idx];
                rd_y <= seg_y_q[rd_idx];
            end else begin
                rd_x <= 5'd31;
                rd_y <= 5'd31;
            end
            // Segments beyond len_q shift too; they are never read or compared.
            if (shift) begin
                seg_x_q[0] <= nx;
                seg_y_q[0] <= ny;
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_q[i] <= seg_x_q[i-1];
                    seg_y_q[i] <= seg_y_q[i-1];
                end
            end
        end
    end

    assign head_x    = seg_x_q[0];
    assign head_y    = seg_y_q[0];
    assign length    = len_q;
    assign step      = step_q;
    assign game_over = (state_q == StOver);

endmodule

// File: tb/tb_snake_motion.sv
// Directed bench for snake_motion with STEP_DIV=4: start, wrap, growth,
// collision and reset-priority scenarios against hand-computed positions.
module tb_snake_motion;

    localparam logic [4:0] Up    = 5'b00010;
    localparam logic [4:0] Left  = 5'b00100;
    localparam logic [4:0] Down  = 5'b01000;
    localparam logic [4:0] Right = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] direction = '0;
    logic       dir_valid = 1'b0;
    logic       grow = 1'b0;
    logic [3:0] rd_idx = '0;
    logic [4:0] rd_x, rd_y, head_x, head_y, length;
    logic       step, game_over;

    int checks = 0;
    int errors = 0;

    snake_motion #(
        .GRID_W  (32),
        .GRID_H  (24),
        .STEP_DIV(4),
        .MAX_LEN (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .direction(direction),
        .dir_valid(dir_valid),
        .grow     (grow),
        .rd_idx   (rd_idx),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .head_x   (head_x),
        .head_y   (head_y),
        .length   (length),
        .step     (step),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_dir(input logic [4:0] d);
        direction = d;
        dir_valid = 1'b1;
        tick();
        dir_valid = 1'b0;
        direction = '0;
    endtask

    task automatic pulse_grow;
        grow = 1'b1;
        tick();
        grow = 1'b0;
    endtask

    task automatic wait_step;
        int n = 0;
        do begin
            tick();
            n++;
        end while (!step && n < 20);
        if (!step) check("step_timeout", 0, 1);
    endtask

    task automatic run_steps(input int n);
        repeat (n) wait_step();
    endtask

    task automatic check_head(input string tag, input int x, input int y);
        check({tag, "_x"}, head_x, x);
        check({tag, "_y"}, head_y, y);
    endtask

    initial begin
        int steps_seen;

        // Reset values
        rst = 1'b1;
        tick();
        do_reset();
        check_head("rst_head", 16, 12);
        check("rst_len", length, 3);
        check("rst_step", step, 0);
        check("rst_over", game_over, 0);
        check("rst_rdx", rd_x, 31);
        check("rst_rdy", rd_y, 31);
        tick();
        check("rd0_x", rd_x, 16);
        check("rd0_y", rd_y, 12);

        // Up starts the run; moves land 4 cycles apart
        send_dir(Up);
        repeat (3) tick();
        check("up_pre_step", step, 0);
        check_head("up_pre", 16, 12);
        tick();
        check("up_step1", step, 1);
        check_head("up1", 16, 11);
        tick();
        check("up_step_clear", step, 0);
        repeat (3) tick();
        check("up_step2", step, 1);
        check_head("up2", 16, 10);

        // Reversal and malformed codes are ignored in IDLE
        do_reset();
        send_dir(Left);
        send_dir(5'b00110);
        repeat (8) tick();
        check_head("idle_hold", 16, 12);
        send_dir(Down);
        wait_step();
        check_head("down1", 16, 13);

        // Edge wrap right and up
        do_reset();
        send_dir(Right);
        run_steps(15);
        check_head("edge_r", 31, 12);
        wait_step();
        check_head("wrap_r", 0, 12);
        do_reset();
        send_dir(Up);
        run_steps(12);
        check_head("edge_u", 16, 0);
        wait_step();
        check_head("wrap_u", 16, 23);

        // Growth keeps the old tail, saturates at 16
        do_reset();
        rd_idx = 4'd3;
        pulse_grow();
        send_dir(Right);
        wait_step();
        check("grow_len4", length, 4);
        check_head("grow1", 17, 12);
        tick();
        check("grow_tail_x", rd_x, 14);
        check("grow_tail_y", rd_y, 12);
        repeat (12) begin
            pulse_grow();
            wait_step();
        end
        check("grow_len16", length, 16);
        check_head("grow16", 29, 12);
        pulse_grow();
        wait_step();
        check("grow_sat", length, 16);
        rd_idx = 4'd15;
        tick();
        check("max_tail_x", rd_x, 15);

        // Self-collision: right x2 growing, up, left, down into the body
        do_reset();
        pulse_grow();
        send_dir(Right);
        wait_step();
        pulse_grow();
        wait_step();
        check("col_len5", length, 5);
        send_dir(Up);
        wait_step();
        send_dir(Left);
        wait_step();
        check_head("col_pre", 17, 11);
        send_dir(Down);
        steps_seen = 0;
        for (int n = 0; n < 20 && !game_over; n++) begin
            tick();
            if (step) steps_seen++;
        end
        check("col_over", game_over, 1);
        check("col_no_step", steps_seen, 0);
        check_head("col_frozen", 17, 11);
        check("col_len", length, 5);
        send_dir(Up);
        pulse_grow();
        repeat (10) tick();
        check_head("over_hold", 17, 11);
        check("over_len", length, 5);
        check("over_stay", game_over, 1);
        rd_idx = 4'd3;
        tick();
        check("over_seg3_x", rd_x, 17);
        check("over_seg3_y", rd_y, 12);
        do_reset();
        check("over_rst", game_over, 0);
        check("over_rst_len", length, 3);

        // Reset wins in the move-evaluation cycle
        rd_idx = 4'd7;
        send_dir(Right);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mv_rst_step", step, 0);
        check_head("mv_rst", 16, 12);
        check("mv_rst_len", length, 3);
        check("mv_rst_over", game_over, 0);
        check("mv_rst_rdx", rd_x, 31);
        tick();
        check("rd7_x", rd_x, 31);
        check("rd7_y", rd_y, 31);
        repeat (6) tick();
        check_head("mv_rst_idle", 16, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_motion.md
SNAKE_MOTION -- requirements
Module: snake_motion

Interface
REQ-001 Parameter GRID_W, default 32, grid columns; x range 0..GRID_W-1.
REQ-002 Parameter GRID_H, default 24, grid rows; y range 0..GRID_H-1.
REQ-003 Parameter STEP_DIV, default 6250000, clk cycles per snake step; minimum 2.
REQ-004 Parameter MAX_LEN, default 16, maximum segment count.
REQ-005 clk  in  1  system clock; the block has one clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 direction  in  5  key code from the PS/2 stage: 00010 up, 00100 left, 01000 down, 10000 right.
REQ-008 dir_valid  in  1  high when direction is valid.
REQ-009 grow  in  1  single-cycle pulse: food eaten.
REQ-010 rd_idx  in  4  segment read index, 0 = head.
REQ-011 rd_x  out  5  x of segment rd_idx, registered.
REQ-012 rd_y  out  5  y of segment rd_idx, registered.
REQ-013 head_x  out  5  current head x.
REQ-014 head_y  out  5  current head y.
REQ-015 length  out  5  current segment count.
REQ-016 step  out  1  one-cycle pulse, high in the cycle after a committed move.
REQ-017 game_over  out  1  high in state OVER.

Function
REQ-018 The state machine SHALL have states IDLE, RUN and OVER; it SHALL reset to IDLE.
REQ-019 Direction SHALL be accepted only when dir_valid=1 and direction is exactly one of the four codes; all other values are ignored.
REQ-020 An accepted direction opposite the committed direction SHALL be ignored; otherwise it overwrites pending_dir (last one wins between steps).
REQ-021 IDLE -> RUN SHALL occur in the cycle after an accepted direction; the step counter SHALL be 0 on entering RUN.
REQ-022 In RUN, the step counter SHALL count 0..STEP_DIV-1 and wrap; a move SHALL be evaluated in the cycle the counter equals STEP_DIV-1.
REQ-023 At a move, committed_dir SHALL become pending_dir and the next head SHALL be the current head plus one cell in that direction.
REQ-024 Edge wrap: x=GRID_W-1 moving right -> 0; x=0 moving left -> GRID_W-1; the same rule applies to y with GRID_H; up SHALL decrement y.
REQ-025 Collision: the next head SHALL be compared in parallel against segments 0..length-1, excluding the tail when no growth is applied at this move.
REQ-026 On collision the state SHALL become OVER, positions and length SHALL stay unchanged, and no step pulse SHALL be issued.
REQ-027 Otherwise all segments SHALL shift one index, segment 0 SHALL become the next head, and step SHALL pulse in the following cycle.
REQ-028 A grow pulse SHALL set grow_pending in any state except OVER; at the next committed move, when length<MAX_LEN, length SHALL increment, the old tail SHALL be kept, and grow_pending SHALL clear.
REQ-029 At length=MAX_LEN, grow_pending SHALL clear at the move without effect.
REQ-030 OVER SHALL freeze all state and ignore direction and grow until rst.
REQ-031 rd_x/rd_y SHALL show segment rd_idx with 1-cycle latency; an rd_idx of length or greater SHALL return 31/31.

Reset
REQ-032 On rst=1 at a clk edge: state IDLE; length 3; segments (16,12),(15,12),(14,12); committed_dir and pending_dir right.
REQ-033 On the same rst edge: counter 0; grow_pending 0; step 0; game_over 0; rd_x/rd_y 31/31.
REQ-034 rst SHALL take priority over every other input, including mid-move and in OVER.

Verification (STEP_DIV=4)
REQ-035 Reset, then up pulse -> RUN; head (16,11) with a step pulse 4 cycles after RUN entry; then (16,10) 4 cycles later.
REQ-036 From reset, left pulse -> ignored, stays IDLE; then down -> RUN, head (16,13).
REQ-037 Head (31,12) moving right -> next head (0,12); head (16,0) moving up -> (16,23).
REQ-038 grow pulse at length 3 -> after the next move, length 4 and the previous tail is retained at idx 3; at 16 segments, grow leaves length at 16.
REQ-039 Length 5, moves up, left, down -> at the next move the down move lands on a body segment: game_over=1, positions unchanged, no step pulse, inputs ignored until rst.
REQ-040 rst asserted in the move-evaluation cycle -> the reset values of REQ-032/REQ-033 in the next cycle with no step pulse; rd_idx=7 at length 3 -> rd_x=rd_y=31.
